// File: rtl/mlp_pkg.sv
// Shared types and per-layer constants for the MLP weight sequencer.
// Layers are stored back to back in the weight ROM, row-major and neuron-major.
package mlp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;

    localparam int L1_N_IN     = 16;
    localparam int L1_N_OUT    = 10;
    localparam int L1_BASE     = 0;
    localparam int L2_N_IN     = 10;
    localparam int L2_N_OUT    = 8;
    localparam int L2_BASE     = L1_BASE + L1_N_IN * L1_N_OUT;
    localparam int L3_N_IN     = 8;
    localparam int L3_N_OUT    = 4;
    localparam int L3_BASE     = L2_BASE + L2_N_IN * L2_N_OUT;

    typedef logic [DATA_W-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Index width for a count of n; a single-entry count still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_index_counter.sv
// Wrap counter: counts 0..MAX-1 on en, returns to 0 after MAX-1 and flags the wrap.
// The wrap flag is combinational so a chained counter can step in the same cycle.
module mlp_index_counter #(
    parameter int MAX = 16,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = en & (cnt_q == LAST);
    assign cnt  = cnt_q;

    // Next count: clear wins over stepping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mlp_weight_sequencer.sv
// Steps the weight ROM address through one fully-connected layer and streams
// (weight, x_idx, n_idx) transfers to the MAC, flagging each neuron boundary.
module mlp_weight_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 10,
    parameter int ADDR_W    = mlp_pkg::ADDR_W,
    parameter int DATA_W    = mlp_pkg::DATA_W,
    parameter int BASE_ADDR = 0,
    localparam int XW       = idx_w(N_IN),
    localparam int NW       = idx_w(N_OUT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [XW-1:0]     x_idx,
    output logic [NW-1:0]     n_idx,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [DATA_W-1:0] mac_weight,
    output logic              mac_first,
    output logic              mac_last
);

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [XW-1:0]     X_LAST = XW'(N_IN - 1);

    if (N_IN < 1 || N_OUT < 1) begin : g_bad_dims
        $error("mlp_weight_sequencer: N_IN and N_OUT must be at least 1");
    end
    if ((BASE_ADDR + N_IN * N_OUT - 1) >= (1 << ADDR_W)) begin : g_bad_range
        $error("mlp_weight_sequencer: last weight address does not fit in ADDR_W");
    end

    seq_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              xfer_s;
    logic              cnt_clr_s;
    logic              x_wrap_s;
    logic              n_wrap_s;
    logic [XW-1:0]     x_cnt_s;
    logic [NW-1:0]     n_cnt_s;

    assign xfer_s    = valid_q & mac_ready;
    assign cnt_clr_s = (state_q != RUN);

    // x_idx carries into n_idx; the last transfer wraps both back to zero.
    mlp_index_counter #(.MAX(N_IN), .W(XW)) u_x_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr_s),
        .en      (xfer_s),
        .cnt     (x_cnt_s),
        .wrap    (x_wrap_s)
    );

    mlp_index_counter #(.MAX(N_OUT), .W(NW)) u_n_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr_s),
        .en      (x_wrap_s),
        .cnt     (n_cnt_s),
        .wrap    (n_wrap_s)
    );

    // Sequencer next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                addr_d  = BASE;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (xfer_s && n_wrap_s) begin
                    // Address holds on the last weight until DONE is left.
                    state_d = DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d = addr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                addr_d  = BASE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                addr_d  = BASE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= BASE;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_valid  = valid_q;
    assign rom_addr   = addr_q;
    assign x_idx      = x_cnt_s;
    assign n_idx      = n_cnt_s;
    assign mac_weight = rom_data;
    assign mac_first  = valid_q & (x_cnt_s == XW'(0));
    assign mac_last   = valid_q & (x_cnt_s == X_LAST);

endmodule

// File: tb/tb_mlp_weight_sequencer.sv
// Directed bench: a 4x3 layer at base 100 and a 1x1 layer at base 50, both fed
// from a fixed weight image.
module tb_mlp_weight_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_a, ready_a, start_b, ready_b;
    logic [13:0] rom_addr_a, rom_addr_b;
    logic [15:0] rom_data_a, rom_data_b, weight_a, weight_b;
    logic [1:0]  x_idx_a, n_idx_a;
    logic [0:0]  x_idx_b, n_idx_b;
    logic        busy_a, done_a, valid_a, first_a, last_a;
    logic        busy_b, done_b, valid_b, first_b, last_b;

    int vecs = 0;
    int miss = 0;

    function automatic logic [15:0] wimg(input logic [13:0] a);
        return 16'hC3A5 ^ (16'(a) * 16'd37);
    endfunction

    assign rom_data_a = wimg(rom_addr_a);
    assign rom_data_b = wimg(rom_addr_b);

    mlp_weight_sequencer #(.N_IN(4), .N_OUT(3), .ADDR_W(14), .DATA_W(16), .BASE_ADDR(100)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .x_idx(x_idx_a), .n_idx(n_idx_a),
        .mac_valid(valid_a), .mac_ready(ready_a), .mac_weight(weight_a),
        .mac_first(first_a), .mac_last(last_a)
    );

    mlp_weight_sequencer #(.N_IN(1), .N_OUT(1), .ADDR_W(14), .DATA_W(16), .BASE_ADDR(50)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .x_idx(x_idx_b), .n_idx(n_idx_b),
        .mac_valid(valid_b), .mac_ready(ready_b), .mac_weight(weight_b),
        .mac_first(first_b), .mac_last(last_b)
    );

    // Drives one 4x3 layer on u_a; optional stall, mid-run start, abort by reset
    // and start during DONE, each keyed by the transfer number (-1 = unused).
    task automatic run_layer_a(input string tag, input int stall_at, input int restart_at,
                               input int abort_at, input bit start_in_done);
        logic [13:0] ea;
        logic [1:0]  ex, en;
        @(negedge clk);
        start_a = 1'b1;
        vecs++;
        if ({valid_a, busy_a, done_a} !== 3'b000) begin
            miss++;
            $display("FAIL %s idle_before_start got %b want 000", tag, {valid_a, busy_a, done_a});
        end
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ea = 14'(100 + i);
            ex = 2'(i % 4);
            en = 2'(i / 4);
            vecs++;
            if ({valid_a, busy_a, done_a} !== 3'b110) begin
                miss++;
                $display("FAIL %s ctrl[%0d] got %b want 110", tag, i, {valid_a, busy_a, done_a});
            end
            vecs++;
            if ({rom_addr_a, x_idx_a, n_idx_a} !== {ea, ex, en}) begin
                miss++;
                $display("FAIL %s index[%0d] got addr=%0d x=%0d n=%0d want addr=%0d x=%0d n=%0d",
                         tag, i, rom_addr_a, x_idx_a, n_idx_a, ea, ex, en);
            end
            vecs++;
            if ({first_a, last_a} !== {ex == 2'd0, ex == 2'd3}) begin
                miss++;
                $display("FAIL %s first_last[%0d] got %b want %b", tag, i,
                         {first_a, last_a}, {ex == 2'd0, ex == 2'd3});
            end
            vecs++;
            if (weight_a !== wimg(ea)) begin
                miss++;
                $display("FAIL %s weight[%0d] got %h want %h", tag, i, weight_a, wimg(ea));
            end
            if (i == abort_at) begin
                reset_n = 1'b0;
                #1;
                vecs++;
                if ({busy_a, valid_a, done_a, rom_addr_a, x_idx_a, n_idx_a} !== {3'b000, 14'd100, 4'd0}) begin
                    miss++;
                    $display("FAIL %s async_reset got busy/valid/done=%b addr=%0d x=%0d n=%0d want 000 100 0 0",
                             tag, {busy_a, valid_a, done_a}, rom_addr_a, x_idx_a, n_idx_a);
                end
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (i == stall_at) begin
                ready_a = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    vecs++;
                    if ({valid_a, busy_a, rom_addr_a, x_idx_a, n_idx_a, first_a, last_a, weight_a} !==
                        {2'b11, ea, ex, en, ex == 2'd0, ex == 2'd3, wimg(ea)}) begin
                        miss++;
                        $display("FAIL %s stall[%0d] got v=%b addr=%0d x=%0d n=%0d w=%h want v=1 addr=%0d x=%0d n=%0d w=%h",
                                 tag, s, valid_a, rom_addr_a, x_idx_a, n_idx_a, weight_a, ea, ex, en, wimg(ea));
                    end
                end
                ready_a = 1'b1;
            end
            if (i == restart_at) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        vecs++;
        if ({valid_a, busy_a, done_a, rom_addr_a} !== {3'b011, 14'd111}) begin
            miss++;
            $display("FAIL %s done_cycle got v/b/d=%b addr=%0d want 011 addr=111",
                     tag, {valid_a, busy_a, done_a}, rom_addr_a);
        end
        if (start_in_done) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        vecs++;
        if ({valid_a, busy_a, done_a, rom_addr_a, x_idx_a, n_idx_a} !== {3'b000, 14'd100, 4'd0}) begin
            miss++;
            $display("FAIL %s back_to_idle got v/b/d=%b addr=%0d x=%0d n=%0d want 000 100 0 0",
                     tag, {valid_a, busy_a, done_a}, rom_addr_a, x_idx_a, n_idx_a);
        end
        @(negedge clk);
        vecs++;
        if ({valid_a, busy_a, done_a} !== 3'b000) begin
            miss++;
            $display("FAIL %s stays_idle got v/b/d=%b want 000", tag, {valid_a, busy_a, done_a});
        end
    endtask

    task automatic test_reset;
        vecs++;
        if ({busy_a, done_a, valid_a, rom_addr_a, x_idx_a, n_idx_a} !== {3'b000, 14'd100, 4'd0}) begin
            miss++;
            $display("FAIL reset_a got b/d/v=%b addr=%0d x=%0d n=%0d want 000 100 0 0",
                     {busy_a, done_a, valid_a}, rom_addr_a, x_idx_a, n_idx_a);
        end
        vecs++;
        if ({busy_b, done_b, valid_b, first_b, last_b, rom_addr_b} !== {5'b00000, 14'd50}) begin
            miss++;
            $display("FAIL reset_b got b/d/v/f/l=%b addr=%0d want 00000 50",
                     {busy_b, done_b, valid_b, first_b, last_b}, rom_addr_b);
        end
    endtask

    task automatic test_full_run;
        run_layer_a("full_run", -1, -1, -1, 1'b0);
    endtask

    task automatic test_stall;
        run_layer_a("stall", 5, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored;
        run_layer_a("restart", -1, 2, -1, 1'b1);
    endtask

    task automatic test_reset_mid_layer;
        run_layer_a("abort", -1, -1, 6, 1'b0);
        run_layer_a("replay", -1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            vecs++;
            if ({valid_b, busy_b, done_b, first_b, last_b, rom_addr_b, x_idx_b, n_idx_b, weight_b} !==
                {5'b11011, 14'd50, 2'b00, wimg(14'd50)}) begin
                miss++;
                $display("FAIL single_xfer[%0d] got v/b/d/f/l=%b addr=%0d w=%h want 11011 50 %h",
                         r, {valid_b, busy_b, done_b, first_b, last_b}, rom_addr_b, weight_b, wimg(14'd50));
            end
            @(negedge clk);
            vecs++;
            if ({valid_b, busy_b, done_b, rom_addr_b} !== {3'b011, 14'd50}) begin
                miss++;
                $display("FAIL single_done[%0d] got v/b/d=%b addr=%0d want 011 50",
                         r, {valid_b, busy_b, done_b}, rom_addr_b);
            end
            @(negedge clk);
            vecs++;
            if ({valid_b, busy_b, done_b} !== 3'b000) begin
                miss++;
                $display("FAIL single_idle[%0d] got v/b/d=%b want 000", r, {valid_b, busy_b, done_b});
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        @(negedge clk);
        test_full_run;
        test_stall;
        test_start_ignored;
        test_reset_mid_layer;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
